// File: rtl/seq_detect_param_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : seq_detect_param_pkg                                           |
// | Purpose : Shared types and constants for the programmable serial         |
// |           pattern detector: config record, reset configuration and the   |
// |           pattern-length mask helper.                                    |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package seq_detect_param_pkg;

  // Storage width of the config record. The pattern field is sized for the
  // largest supported MAX_LEN (31, so that {history, inp} fits); the length
  // field must hold any LEN_W the top is built with (LEN_W <= CFG_LEN_W).
  // LEN_W itself must be wide enough to hold MAX_LEN, i.e.
  // LEN_W >= $clog2(MAX_LEN+1).
  localparam int unsigned CFG_PAT_W = 32;
  localparam int unsigned CFG_LEN_W = 8;

  // Configuration in force after reset: overlapping Mealy detector of 1011.
  localparam logic [CFG_PAT_W-1:0] RST_PATTERN = 32'h0000_000B;
  localparam logic [CFG_LEN_W-1:0] RST_LEN     = 8'd4;
  localparam logic                 RST_OVERLAP = 1'b1;
  localparam logic                 RST_MOORE   = 1'b0;

  typedef struct packed {
    logic [CFG_PAT_W-1:0] pattern;
    logic [CFG_LEN_W-1:0] len;
    logic                 overlap;
    logic                 moore;
  } cfg_t;

  localparam cfg_t RST_CFG = '{
    pattern: RST_PATTERN,
    len:     RST_LEN,
    overlap: RST_OVERLAP,
    moore:   RST_MOORE
  };

  // Mask selecting the low 'len' bits; bits at or above len are don't-care.
  function automatic logic [CFG_PAT_W-1:0] len_mask(input logic [CFG_LEN_W-1:0] len);
    logic [CFG_PAT_W-1:0] m;
    if (32'(len) >= CFG_PAT_W) begin
      m = '1;
    end else begin
      m = (CFG_PAT_W'(1) << len) - CFG_PAT_W'(1);
    end
    return m;
  endfunction

endpackage : seq_detect_param_pkg
`default_nettype wire

// File: rtl/seq_detect_param_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sat_counter                                                    |
// | Purpose : Saturating up-counter with synchronous clear. A clear that     |
// |           coincides with an increment leaves the count at 1 so the       |
// |           coincident event is not lost.                                  |
// | Ports   : clk_i    clock                                                 |
// |           rst_n_i  synchronous active-low reset                          |
// |           inc_i    count one event                                       |
// |           clr_i    clear the count                                        |
// |           count_o  current count, saturates at all-ones                  |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = inc_i ? CNT_W'(1) : '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/seq_detect_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : seq_detect_param                                               |
// | Purpose : Runtime-programmable serial bit-pattern detector. Pattern,     |
// |           length, overlap mode and Mealy/Moore output timing are loaded  |
// |           at runtime; input bits are qualified by in_valid_i and each    |
// |           occurrence is counted in a saturating counter.                 |
// | Ports   : clk_i          clock                                           |
// |           rst_n_i        synchronous active-low reset                    |
// |           cfg_load_i     latch cfg_*_i and restart detection             |
// |           cfg_pattern_i  pattern, bit [len-1] received first             |
// |           cfg_len_i      pattern length, legal 1..MAX_LEN                |
// |           cfg_overlap_i  1 = overlapping matches                         |
// |           cfg_moore_i    1 = Moore timing (one extra cycle)              |
// |           in_valid_i     qualifies inp_i                                 |
// |           inp_i          serial data bit                                 |
// |           cnt_clr_i      clear match_count_o                             |
// |           match_o        one-cycle pulse per occurrence                  |
// |           match_count_o  saturating count of match pulses                |
// |           cfg_err_o      latched length is illegal; detection disabled   |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module seq_detect_param
  import seq_detect_param_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               cfg_load_i,
  input  logic [MAX_LEN-1:0] cfg_pattern_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic               cfg_overlap_i,
  input  logic               cfg_moore_i,
  input  logic               in_valid_i,
  input  logic               inp_i,
  input  logic               cnt_clr_i,
  output logic               match_o,
  output logic [CNT_W-1:0]   match_count_o,
  output logic               cfg_err_o
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  cfg_t               cfg_q;
  cfg_t               cfg_d;
  logic               cfg_err_q;
  logic               cfg_err_d;
  logic [MAX_LEN-1:0] hist_q;
  logic [MAX_LEN-1:0] hist_d;
  logic [LEN_W-1:0]   fill_q;
  logic [LEN_W-1:0]   fill_d;
  logic               hit_q;      // Mealy-timed hit (one cycle after sample)
  logic               moore_q;    // extra stage for Moore timing

  // ---------------------------------------------------------------------------
  // Comparator
  // ---------------------------------------------------------------------------
  logic [MAX_LEN:0]     window;
  logic [CFG_PAT_W-1:0] window_ext;
  logic [CFG_PAT_W-1:0] mask;
  logic                 pat_eq;
  logic                 len_ok;
  logic                 hit;

  // The incoming bit is compared together with the history so a match is
  // recognised on the same edge that samples the completing bit.
  assign window     = {hist_q, inp_i};
  assign window_ext = CFG_PAT_W'(window);
  assign mask       = len_mask(cfg_q.len);
  assign pat_eq     = ((window_ext ^ cfg_q.pattern) & mask) == '0;
  // Enough bits must have arrived since the last restart to fill the pattern.
  assign len_ok     = (32'(fill_q) + 32'd1) >= 32'(cfg_q.len);
  // A load in the same cycle discards the bit, so it can never complete a hit.
  assign hit        = in_valid_i && !cfg_load_i && !cfg_err_q && len_ok && pat_eq;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    cfg_d     = cfg_q;
    cfg_err_d = cfg_err_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    if (cfg_load_i) begin
      cfg_d.pattern = CFG_PAT_W'(cfg_pattern_i);
      cfg_d.len     = CFG_LEN_W'(cfg_len_i);
      cfg_d.overlap = cfg_overlap_i;
      cfg_d.moore   = cfg_moore_i;
      cfg_err_d     = (cfg_len_i == '0) || (32'(cfg_len_i) > MAX_LEN);
      hist_d        = '0;
      fill_d        = '0;
    end else if (in_valid_i) begin
      hist_d = {hist_q[MAX_LEN-2:0], inp_i};
      if (hit && !cfg_q.overlap) begin
        // Non-overlapping: the next occurrence must be built from fresh bits.
        fill_d = '0;
      end else if (32'(fill_q) < MAX_LEN) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cfg_q     <= RST_CFG;
      cfg_err_q <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      hit_q     <= 1'b0;
      moore_q   <= 1'b0;
    end else begin
      cfg_q     <= cfg_d;
      cfg_err_q <= cfg_err_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      hit_q     <= hit;
      // Advances regardless of in_valid_i so a pending Moore pulse still
      // comes out; a load flushes it.
      moore_q   <= cfg_load_i ? 1'b0 : hit_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    match_o = hit_q;
    if (cfg_q.moore) begin
      match_o = moore_q;
    end
  end

  assign cfg_err_o = cfg_err_q;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (match_o),
    .clr_i   (cnt_clr_i),
    .count_o (match_count_o)
  );

endmodule : seq_detect_param
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_seq_detect_param                                            |
// | Purpose : Directed self-checking bench for seq_detect_param, built with  |
// |           a 2-bit match counter so saturation is reachable quickly.      |
// | Ports   : none                                                           |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_seq_detect_param;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned CNT_W   = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cfg_moore;
  logic               in_valid;
  logic               inp;
  logic               cnt_clr;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  int base  = 0;

  always #5 clk = ~clk;

  seq_detect_param #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .cfg_load_i    (cfg_load),
    .cfg_pattern_i (cfg_pattern),
    .cfg_len_i     (cfg_len),
    .cfg_overlap_i (cfg_overlap),
    .cfg_moore_i   (cfg_moore),
    .in_valid_i    (in_valid),
    .inp_i         (inp),
    .cnt_clr_i     (cnt_clr),
    .match_o       (match),
    .match_count_o (match_count),
    .cfg_err_o     (cfg_err)
  );

  // Running count of match pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (match === 1'b1) pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic b);
    in_valid = 1'b1;
    inp      = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Sends bits[n-1] first.
  task automatic send_stream(input logic [15:0] bits, input int n);
    logic [15:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) send(v[i]);
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len,
                      input logic ov, input logic mo);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    cfg_moore   = mo;
    cfg_load    = 1'b1;
    tick();
    cfg_load    = 1'b0;
  endtask

  task automatic clear_count();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    cfg_moore   = 1'b0;
    in_valid    = 1'b0;
    inp         = 1'b0;
    cnt_clr     = 1'b0;

    // Reset state
    idle(2);
    chk("rst_match", 32'(match), 0);
    chk("rst_count", 32'(match_count), 0);
    chk("rst_err", 32'(cfg_err), 0);
    rst_n = 1'b1;
    tick();

    // 1: reset config detects 1011 with Mealy timing
    send(1'b1);
    chk("t1_bit1", 32'(match), 0);
    send(1'b0);
    send(1'b1);
    chk("t1_bit3", 32'(match), 0);
    send(1'b1);
    chk("t1_hit", 32'(match), 1);
    tick();
    chk("t1_pulse_end", 32'(match), 0);
    chk("t1_count", 32'(match_count), 1);

    // 2: overlap vs non-overlap on 1011011
    clear_count();
    chk("t2_clr", 32'(match_count), 0);
    load(8'h0B, 4'd4, 1'b1, 1'b0);
    base = pulses;
    send_stream(16'h005B, 7);
    idle(3);
    chk("t2_ovl_pulses", 32'(pulses - base), 2);
    chk("t2_ovl_count", 32'(match_count), 2);
    clear_count();
    load(8'h0B, 4'd4, 1'b0, 1'b0);
    base = pulses;
    send_stream(16'h005B, 7);
    idle(3);
    chk("t2_novl_pulses", 32'(pulses - base), 1);
    chk("t2_novl_count", 32'(match_count), 1);

    // 3: Moore timing, then with in_valid gaps
    load(8'h0B, 4'd4, 1'b1, 1'b1);
    send_stream(16'h000B, 4);
    chk("t3_lat1", 32'(match), 0);
    tick();
    chk("t3_lat2", 32'(match), 1);
    tick();
    chk("t3_end", 32'(match), 0);
    load(8'h0B, 4'd4, 1'b1, 1'b1);
    base = pulses;
    send(1'b1); tick();
    send(1'b0); tick();
    send(1'b1); tick();
    send(1'b1); tick();
    idle(3);
    chk("t3_gap_pulses", 32'(pulses - base), 1);

    // 4: full-length pattern, then illegal lengths
    load(8'hA5, 4'd8, 1'b1, 1'b0);
    chk("t4_err_ok", 32'(cfg_err), 0);
    base = pulses;
    send_stream(16'h00A5, 8);
    idle(2);
    chk("t4_a5_pulses", 32'(pulses - base), 1);
    load(8'hA5, 4'd0, 1'b1, 1'b0);
    chk("t4_err_len0", 32'(cfg_err), 1);
    base = pulses;
    send_stream(16'h00A5, 8);
    idle(2);
    chk("t4_err_pulses", 32'(pulses - base), 0);
    load(8'hA5, 4'd9, 1'b1, 1'b0);
    chk("t4_err_len9", 32'(cfg_err), 1);
    load(8'hA5, 4'd8, 1'b1, 1'b0);
    chk("t4_err_clear", 32'(cfg_err), 0);

    // 5: counter saturation and clear coincident with match
    clear_count();
    load(8'h0B, 4'd4, 1'b1, 1'b0);
    base = pulses;
    send_stream(16'hB6DB, 16);
    idle(2);
    chk("t5_pulses", 32'(pulses - base), 5);
    chk("t5_sat", 32'(match_count), 3);
    send_stream(16'h0003, 3);
    chk("t5_hit", 32'(match), 1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("t5_clr_hit", 32'(match_count), 1);

    // 6: reset mid-pattern reverts config; load beats a coincident bit
    load(8'h0B, 4'd4, 1'b1, 1'b1);
    send_stream(16'h0005, 3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_rst_count", 32'(match_count), 0);
    chk("t6_rst_match", 32'(match), 0);
    base = pulses;
    send(1'b1);
    idle(3);
    chk("t6_no_match", 32'(pulses - base), 0);
    send_stream(16'h0003, 3);
    chk("t6_mealy_back", 32'(match), 1);
    idle(2);
    cfg_pattern = 8'h0B;
    cfg_len     = 4'd4;
    cfg_overlap = 1'b1;
    cfg_moore   = 1'b0;
    cfg_load    = 1'b1;
    in_valid    = 1'b1;
    inp         = 1'b1;
    tick();
    cfg_load    = 1'b0;
    in_valid    = 1'b0;
    base = pulses;
    send_stream(16'h0003, 3);
    idle(3);
    chk("t6_load_wins", 32'(pulses - base), 0);
    send(1'b1);
    idle(2);
    chk("t6_after_load", 32'(pulses - base), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_seq_detect_param
`default_nettype wire
